car_lamp_ctrl: RTL and testbench

Parametrised rear-lamp controller, the next generation of the fixed 3-LED `water_lamp`. It drives two LED_W-wide lamp banks with a left, right or hazard filling ("water") sweep, brake and door patterns. The sweep runs at a programmable step rate. A two-digit 7-segment display shows how many sweep cycles have completed in the current mode. It sits between the switch/pedal inputs and the board LED and segment pins.

---
 rtl/car_lamp_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 40 ++++
 rtl/car_lamp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_car_lamp_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/car_lamp_pkg.sv
// -----------------------------------------------------------------------------
// car_lamp_pkg
// Shared definitions for the rear-lamp controller:
//   - mode_t  : resolved lamp mode, held in the controller's mode register
//   - SEG_*   : 7-segment patterns {g,f,e,d,c,b,a}, 1 = segment lit
// Optional display build macro: CAR_LAMP_DISP_EN (see car_lamp_ctrl).
// -----------------------------------------------------------------------------
package car_lamp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEFT    = 3'd1,
      RIGHT   = 3'd2,
      HAZARD  = 3'd3,
      BRAKE   = 3'd4,
      BRAKE_L = 3'd5,
      BRAKE_R = 3'd6,
      DOOR    = 3'd7
   } mode_t;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// BCD digit to 7-segment pattern, purely combinational.
// Ports:
//   bcd   in  4 : BCD digit 0..9 (codes 10..15 show blank)
//   blank in  1 : 1 forces all segments off
//   seg   out 7 : {g,f,e,d,c,b,a}, 1 = lit
// Only compiled when CAR_LAMP_DISP_EN is defined; without the display the
// module has no user and would otherwise appear as a stray top level.
// -----------------------------------------------------------------------------
`ifdef CAR_LAMP_DISP_EN
module seg7_decode
   import car_lamp_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule
`endif

// File: rtl/car_lamp_ctrl.sv
// -----------------------------------------------------------------------------
// car_lamp_ctrl
// Rear-lamp controller: two LED_W-wide banks showing left/right/hazard
// filling sweeps, brake and door patterns, plus a two-digit count of sweep
// cycles completed in the current mode.
// Parameters:
//   LED_W    : LEDs per side (1..16)
//   STEP_DIV : clock cycles per animation step (>= 2)
// Ports:
//   clk        in  1     : clock, rising edge
//   rstN       in  1     : asynchronous active-low reset
//   rstL/rstR  in  1     : left / right turn requests (level)
//   rstHazard  in  1     : hazard request (level)
//   rstBrake   in  1     : brake pedal (level)
//   rstDoor    in  1     : door open (level)
//   ledL/ledR  out LED_W : lamp banks, bit 0 innermost, 1 = lit
//   ledNum1    out 7     : tens digit {g,f,e,d,c,b,a}
//   ledNum2    out 7     : ones digit
// Build option: define CAR_LAMP_DISP_EN to include the BCD counter and
// 7-segment display; otherwise both digit outputs are tied to 0.
// -----------------------------------------------------------------------------
module car_lamp_ctrl
   import car_lamp_pkg::*;
#(
   parameter int LED_W    = 3,
   parameter int STEP_DIV = 5_000_000
)(
   input  logic             clk,
   input  logic             rstN,
   input  logic             rstL,
   input  logic             rstR,
   input  logic             rstHazard,
   input  logic             rstBrake,
   input  logic             rstDoor,
   output logic [LED_W-1:0] ledL,
   output logic [LED_W-1:0] ledR,
   output logic [6:0]       ledNum1,
   output logic [6:0]       ledNum2
);

   localparam int PW = $clog2(LED_W + 1);
   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   mode_t            mode_q, mode_d;
   logic [CW-1:0]    pre_q, pre_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             mode_load;
   logic             step;
   logic             sweep_mode;
   logic             phase_full;
   logic [LED_W-1:0] sweep_mask;
   logic [LED_W-1:0] door_mask;

   // Strict-priority mode resolution from the raw request levels.
   always_comb begin
      mode_d = IDLE;
      if (rstHazard || (rstL && rstR)) mode_d = HAZARD;
      else if (rstBrake && rstL)       mode_d = BRAKE_L;
      else if (rstBrake && rstR)       mode_d = BRAKE_R;
      else if (rstBrake)               mode_d = BRAKE;
      else if (rstL)                   mode_d = LEFT;
      else if (rstR)                   mode_d = RIGHT;
      else if (rstDoor)                mode_d = DOOR;
   end

   assign mode_load  = (mode_d != mode_q);
   assign step       = (pre_q == CW'(STEP_DIV - 1));
   assign sweep_mode = (mode_q inside {LEFT, RIGHT, HAZARD, BRAKE_L, BRAKE_R});
   assign phase_full = (phase_q == PW'(LED_W));

   // A mode load restarts the animation, and beats a coincident step.
   always_comb begin
      pre_d   = pre_q + 1'b1;
      phase_d = phase_q;
      if (mode_load) begin
         pre_d   = '0;
         phase_d = '0;
      end else if (step) begin
         pre_d = '0;
         if (sweep_mode) begin
            phase_d = phase_full ? '0 : phase_q + 1'b1;
         end else if (mode_q == DOOR) begin
            // Door reuses phase as an on/off flag: 0 = off, 1 = on.
            phase_d = (phase_q == '0) ? PW'(1) : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mode_q  <= IDLE;
         pre_q   <= '0;
         phase_q <= '0;
      end else begin
         mode_q  <= mode_d;
         pre_q   <= pre_d;
         phase_q <= phase_d;
      end
   end

   // Phase p lights the p lowest LEDs.
   generate
      for (genvar gi = 0; gi < LED_W; gi++) begin : g_mask
         assign sweep_mask[gi] = (PW'(gi) < phase_q);
      end
   endgenerate

   assign door_mask = (phase_q != '0) ? {LED_W{1'b1}} : '0;

   always_comb begin
      ledL = '0;
      ledR = '0;
      case (mode_q)
         LEFT:    ledL = sweep_mask;
         RIGHT:   ledR = sweep_mask;
         HAZARD:  begin ledL = sweep_mask;     ledR = sweep_mask;     end
         BRAKE:   begin ledL = {LED_W{1'b1}};  ledR = {LED_W{1'b1}};  end
         BRAKE_L: begin ledL = sweep_mask;     ledR = {LED_W{1'b1}};  end
         BRAKE_R: begin ledL = {LED_W{1'b1}};  ledR = sweep_mask;     end
         DOOR:    begin ledL = door_mask;      ledR = door_mask;      end
         default: begin ledL = '0;             ledR = '0;             end
      endcase
   end

`ifdef CAR_LAMP_DISP_EN
   logic       cycle_done;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;

   // Cycle events: sweep wrap, door off->on, or every step while braking.
   assign cycle_done = !mode_load && step &&
                       ((sweep_mode && phase_full) ||
                        ((mode_q == DOOR) && (phase_q == '0)) ||
                        (mode_q == BRAKE));

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (mode_load) begin
         tens_d = '0;
         ones_d = '0;
      end else if (cycle_done && !((tens_q == 4'd9) && (ones_q == 4'd9))) begin
         if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 1'b1;
         end else begin
            ones_d = ones_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   seg7_decode u_seg_tens (
      .bcd   (tens_q),
      .blank (mode_q == IDLE),
      .seg   (ledNum1)
   );

   seg7_decode u_seg_ones (
      .bcd   (ones_q),
      .blank (mode_q == IDLE),
      .seg   (ledNum2)
   );
`else
   assign ledNum1 = 7'h00;
   assign ledNum2 = 7'h00;
`endif

endmodule

// File: tb/tb_car_lamp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_lamp_ctrl
// Bench for car_lamp_ctrl with LED_W=3, STEP_DIV=4. A reference model tracks
// the mode and the number of cycles spent in it; outputs follow from that
// elapsed time arithmetically. Digits are expected blank-free only when
// CAR_LAMP_DISP_EN is defined.
// -----------------------------------------------------------------------------
module tb_car_lamp_ctrl;
   import car_lamp_pkg::*;

   localparam int LW = 3;
   localparam int SD = 4;
`ifdef CAR_LAMP_DISP_EN
   localparam bit DISP = 1'b1;
`else
   localparam bit DISP = 1'b0;
`endif

   // request vector packing: {hazard, brake, door, left, right}
   localparam logic [4:0] R_NONE = 5'b00000;
   localparam logic [4:0] R_L    = 5'b00010;
   localparam logic [4:0] R_R    = 5'b00001;
   localparam logic [4:0] R_LR   = 5'b00011;
   localparam logic [4:0] R_BL   = 5'b01010;
   localparam logic [4:0] R_B    = 5'b01000;
   localparam logic [4:0] R_D    = 5'b00100;
   localparam logic [4:0] R_H    = 5'b10000;
   localparam logic [4:0] R_ALL  = 5'b11111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_l, req_r, req_haz, req_brk, req_door;
   logic [LW-1:0] led_l, led_r;
   logic [6:0]    num1, num2;

   int checks   = 0;
   int failures = 0;

   mode_t mode_m;
   int    t_m;

   car_lamp_ctrl #(.LED_W(LW), .STEP_DIV(SD)) dut (
      .clk       (clk),
      .rstN      (rst_n),
      .rstL      (req_l),
      .rstR      (req_r),
      .rstHazard (req_haz),
      .rstBrake  (req_brk),
      .rstDoor   (req_door),
      .ledL      (led_l),
      .ledR      (led_r),
      .ledNum1   (num1),
      .ledNum2   (num2)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d, input bit blank);
      logic [6:0] tab [10];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      if (!DISP || blank) return 7'h00;
      return tab[d];
   endfunction

   function automatic mode_t resolve(input logic [4:0] rq);
      logic hz, bk, dr, l, r;
      {hz, bk, dr, l, r} = rq;
      if (hz || (l && r)) return HAZARD;
      if (bk && l)        return BRAKE_L;
      if (bk && r)        return BRAKE_R;
      if (bk)             return BRAKE;
      if (l)              return LEFT;
      if (r)              return RIGHT;
      if (dr)             return DOOR;
      return IDLE;
   endfunction

   // Expected outputs from elapsed time in the current mode.
   function automatic logic [19:0] model_out();
      int steps, p, cyc;
      logic [2:0] sw, el, er;
      bit blank;
      steps = t_m / SD;
      p     = steps % (LW + 1);
      sw    = 3'((1 << p) - 1);
      el = '0; er = '0; cyc = 0; blank = 1'b0;
      case (mode_m)
         LEFT:    begin el = sw;     cyc = t_m / (SD * (LW + 1)); end
         RIGHT:   begin er = sw;     cyc = t_m / (SD * (LW + 1)); end
         HAZARD:  begin el = sw;     er = sw;     cyc = t_m / (SD * (LW + 1)); end
         BRAKE_L: begin el = sw;     er = 3'b111; cyc = t_m / (SD * (LW + 1)); end
         BRAKE_R: begin el = 3'b111; er = sw;     cyc = t_m / (SD * (LW + 1)); end
         BRAKE:   begin el = 3'b111; er = 3'b111; cyc = steps; end
         DOOR:    begin
            if (steps % 2 == 1) begin el = 3'b111; er = 3'b111; end
            cyc = (steps + 1) / 2;
         end
         default: blank = 1'b1;
      endcase
      if (cyc > 99) cyc = 99;
      return {el, er, seg_of(cyc / 10, blank), seg_of(cyc % 10, blank)};
   endfunction

   task automatic cmp(input string nm, input logic [19:0] exp);
      logic [19:0] got;
      got = {led_l, led_r, num1, num2};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got L=%b R=%b n1=%h n2=%h, expected L=%b R=%b n1=%h n2=%h",
                  nm, $time, got[19:17], got[16:14], got[13:7], got[6:0],
                  exp[19:17], exp[16:14], exp[13:7], exp[6:0]);
      end
   endtask

   // Drive requests, take one edge, advance the model, check 1 time unit later.
   task automatic tick(input logic [4:0] rq);
      mode_t nm;
      {req_haz, req_brk, req_door, req_l, req_r} = rq;
      @(posedge clk);
      if (!rst_n) begin
         mode_m = IDLE;
         t_m    = 0;
      end else begin
         nm = resolve(rq);
         if (nm != mode_m) begin
            mode_m = nm;
            t_m    = 0;
         end else begin
            t_m++;
         end
      end
      #1;
      cmp("model", model_out());
   endtask

   task automatic hold(input logic [4:0] rq, input int n);
      for (int k = 0; k < n; k++) tick(rq);
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic reset_pulse(input logic [4:0] rq);
      #2 rst_n = 1'b0;
      #1;
      mode_m = IDLE;
      t_m    = 0;
      cmp("async_reset", 20'h0);
      tick(rq);
      rst_n = 1'b1;
   endtask

   function automatic logic [19:0] vec(input logic [2:0] el, input logic [2:0] er,
                                       input int tens, input int ones);
      bit bl;
      bl = (tens < 0);
      return {el, er, seg_of(bl ? 0 : tens, bl), seg_of(bl ? 0 : ones, bl)};
   endfunction

   typedef struct {
      logic [4:0] rq;
      int         n;
      logic [2:0] el;
      logic [2:0] er;
      int         tens;   // -1: display blank
      int         ones;
      string      name;
   } tv_t;

   tv_t tv [17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{R_L,    1, 3'b000, 3'b000,  0, 0, "left_entry"};
      tv[1]  = '{R_L,    4, 3'b001, 3'b000,  0, 0, "left_p1"};
      tv[2]  = '{R_L,    4, 3'b011, 3'b000,  0, 0, "left_p2"};
      tv[3]  = '{R_L,    4, 3'b111, 3'b000,  0, 0, "left_p3"};
      tv[4]  = '{R_L,    4, 3'b000, 3'b000,  0, 1, "left_wrap"};
      tv[5]  = '{R_BL,   1, 3'b000, 3'b111,  0, 0, "brake_l_entry"};
      tv[6]  = '{R_BL,   6, 3'b001, 3'b111,  0, 0, "brake_l_p1"};
      tv[7]  = '{R_B,    1, 3'b111, 3'b111,  0, 0, "brake_entry"};
      tv[8]  = '{R_B,    8, 3'b111, 3'b111,  0, 2, "brake_steps"};
      tv[9]  = '{R_D,    1, 3'b000, 3'b000,  0, 0, "door_entry"};
      tv[10] = '{R_D,    4, 3'b111, 3'b111,  0, 1, "door_on"};
      tv[11] = '{R_D,    4, 3'b000, 3'b000,  0, 1, "door_off"};
      tv[12] = '{R_D,    4, 3'b111, 3'b111,  0, 2, "door_on2"};
      tv[13] = '{R_NONE, 1, 3'b000, 3'b000, -1, 0, "idle"};
      tv[14] = '{R_R,    9, 3'b000, 3'b011,  0, 0, "right_p2"};
      tv[15] = '{R_LR,   5, 3'b001, 3'b001,  0, 0, "hazard_lr"};
      tv[16] = '{R_ALL,  4, 3'b011, 3'b011,  0, 0, "hazard_all"};

      // Reset with every request active.
      rst_n = 1'b0;
      {req_haz, req_brk, req_door, req_l, req_r} = R_ALL;
      mode_m = IDLE;
      t_m    = 0;
      #3;
      cmp("reset_state", 20'h0);
      hold(R_ALL, 2);
      rst_n = 1'b1;

      // Table-driven sequence.
      for (int i = 0; i < 17; i++) begin
         hold(tv[i].rq, tv[i].n);
         cmp(tv[i].name, vec(tv[i].el, tv[i].er, tv[i].tens, tv[i].ones));
      end

      // Mode change coinciding with a step: change wins, p restarts at 0.
      hold(R_L, 4);
      tick(R_R);
      cmp("change_on_step", vec(3'b000, 3'b000, 0, 0));
      hold(R_R, 4);
      cmp("first_step_after_change", vec(3'b000, 3'b001, 0, 0));
      // Mode change coinciding with a wrap: no cycle counted.
      hold(R_L, 16);
      cmp("left_before_wrap", vec(3'b111, 3'b000, 0, 0));
      tick(R_BL);
      cmp("change_on_wrap", vec(3'b000, 3'b111, 0, 0));

      // Saturation of the cycle count.
      tick(R_NONE);
      hold(R_L, 1 + 99 * 16 - 1);
      cmp("count_98", vec(3'b111, 3'b000, 9, 8));
      tick(R_L);
      cmp("count_99", vec(3'b000, 3'b000, 9, 9));
      hold(R_L, 16);
      cmp("count_saturated", vec(3'b000, 3'b000, 9, 9));
      tick(R_LR);
      cmp("sat_to_hazard", vec(3'b000, 3'b000, 0, 0));

      // Asynchronous reset mid-sweep, then resume.
      hold(R_L, 10);
      cmp("pre_reset_sweep", vec(3'b011, 3'b000, 0, 0));
      reset_pulse(R_L);
      tick(R_L);
      cmp("post_reset_entry", vec(3'b000, 3'b000, 0, 0));
      hold(R_L, 4);
      cmp("post_reset_p1", vec(3'b001, 3'b000, 0, 0));

      // Randomized segments checked each cycle against the model.
      for (int s = 0; s < 150; s++) begin
         logic [4:0] pats [8];
         logic [4:0] rq;
         pats = '{R_NONE, R_L, R_R, R_LR, R_BL, R_B, R_D, R_H};
         if ($urandom_range(0, 3) == 0) rq = 5'($urandom);
         else                           rq = pats[$urandom_range(0, 7)];
         if ($urandom_range(0, 29) == 0) reset_pulse(rq);
         hold(rq, $urandom_range(1, 40));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
